// File: rtl/game_status_ctrl.sv
// rtl/game_status_ctrl.sv - block-game score/state controller with paced BCD score counting.
// Define HISCORE_TRACK_EN to build the Highest-score registers; otherwise Highest* are tied to 0.
module game_status_ctrl #(
    parameter logic [6:0] WIN_SCORE = 7'd40
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Start,
    input  logic       Clear_Valid,
    input  logic [2:0] Lines_Cleared,
    input  logic       Top_Out,
    output logic [6:0] Score,
    output logic [3:0] Score_Tens,
    output logic [3:0] Score_Ones,
    output logic [6:0] Highest,
    output logic [3:0] Highest_Tens,
    output logic [3:0] Highest_Ones,
    output logic       Playing,
    output logic       Win,
    output logic       Lose,
    output logic       Busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_WIN  = 2'd2,
        ST_LOSE = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [4:0] pending_q, pending_d;
    logic [6:0] score_d;
    logic [3:0] tens_d, ones_d;
    logic [3:0] points;
    logic       at_max, at_win, step;
    logic [5:0] pend_sum;

    always_comb begin
        case (Lines_Cleared)
            3'd1:    points = 4'd1;
            3'd2:    points = 4'd3;
            3'd3:    points = 4'd5;
            3'd4:    points = 4'd8;
            default: points = 4'd0;
        endcase
    end

    assign at_max = (Score == 7'd99);
    assign at_win = (Score == WIN_SCORE);
    // The score advances one point per cycle; the win-check cycle never also counts.
    assign step   = (state_q == ST_PLAY) && !at_win && !at_max && (pending_q != 5'd0);
    assign pend_sum = {1'b0, pending_q}
                    + (Clear_Valid ? {2'b00, points} : 6'd0)
                    - {5'd0, step};

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        score_d   = Score;
        tens_d    = Score_Tens;
        ones_d    = Score_Ones;
        if (Start) begin
            state_d   = ST_PLAY;
            pending_d = 5'd0;
            score_d   = 7'd0;
            tens_d    = 4'd0;
            ones_d    = 4'd0;
        end else if (state_q == ST_PLAY) begin
            if (step) begin
                score_d = Score + 7'd1;
                if (Score_Ones == 4'd9) begin
                    ones_d = 4'd0;
                    tens_d = Score_Tens + 4'd1;
                end else begin
                    ones_d = Score_Ones + 4'd1;
                end
            end
            if (Top_Out) begin
                state_d   = ST_LOSE;
                pending_d = 5'd0;
            end else if (at_win) begin
                state_d   = ST_WIN;
                pending_d = 5'd0;
            end else if (at_max) begin
                pending_d = 5'd0;
            end else begin
                pending_d = (pend_sum > 6'd31) ? 5'd31 : pend_sum[4:0];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            pending_q  <= 5'd0;
            Score      <= 7'd0;
            Score_Tens <= 4'd0;
            Score_Ones <= 4'd0;
            Playing    <= 1'b0;
            Win        <= 1'b0;
            Lose       <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            Score      <= score_d;
            Score_Tens <= tens_d;
            Score_Ones <= ones_d;
            Playing    <= (state_d == ST_PLAY);
            Win        <= (state_d == ST_WIN);
            Lose       <= (state_d == ST_LOSE);
        end
    end

    assign Busy = (pending_q != 5'd0);

`ifdef HISCORE_TRACK_EN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Highest      <= 7'd0;
            Highest_Tens <= 4'd0;
            Highest_Ones <= 4'd0;
        end else if (Score > Highest) begin
            Highest      <= Score;
            Highest_Tens <= Score_Tens;
            Highest_Ones <= Score_Ones;
        end
    end
`else
    assign Highest      = 7'd0;
    assign Highest_Tens = 4'd0;
    assign Highest_Ones = 4'd0;
`endif

endmodule

// File: tb/tb_game_status_ctrl.sv
// tb/tb_game_status_ctrl.sv - scoreboard bench for game_status_ctrl (WIN_SCORE 40 and 99 instances).
module tb_game_status_ctrl;

    localparam logic [2:0] F_IDLE = 3'b000;
    localparam logic [2:0] F_PLAY = 3'b100;
    localparam logic [2:0] F_WIN  = 3'b010;
    localparam logic [2:0] F_LOSE = 3'b001;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, clr = 1'b0, top = 1'b0;
    logic [2:0] lines = 3'd0;
    logic       s9 = 1'b0, c9 = 1'b0, t9 = 1'b0;
    logic [2:0] l9 = 3'd0;

    logic [6:0] score_a, high_a, score_b, high_b;
    logic [3:0] st_a, so_a, ht_a, ho_a, st_b, so_b, ht_b, ho_b;
    logic       pl_a, wn_a, ls_a, bz_a, pl_b, wn_b, ls_b, bz_b;

    game_status_ctrl dut (
        .Clk(clk), .Reset(rst), .Start(start), .Clear_Valid(clr),
        .Lines_Cleared(lines), .Top_Out(top),
        .Score(score_a), .Score_Tens(st_a), .Score_Ones(so_a),
        .Highest(high_a), .Highest_Tens(ht_a), .Highest_Ones(ho_a),
        .Playing(pl_a), .Win(wn_a), .Lose(ls_a), .Busy(bz_a)
    );

    game_status_ctrl #(.WIN_SCORE(7'd99)) dut99 (
        .Clk(clk), .Reset(rst), .Start(s9), .Clear_Valid(c9),
        .Lines_Cleared(l9), .Top_Out(t9),
        .Score(score_b), .Score_Tens(st_b), .Score_Ones(so_b),
        .Highest(high_b), .Highest_Tens(ht_b), .Highest_Ones(ho_b),
        .Playing(pl_b), .Win(wn_b), .Lose(ls_b), .Busy(bz_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        int          which;
        logic [33:0] v;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: each negedge, every expectation tagged for this cycle is popped and checked.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t        e;
            logic [33:0] act;
            e = sb.pop_front();
            if (e.which == 0)
                act = {score_a, st_a, so_a, high_a, ht_a, ho_a, pl_a, wn_a, ls_a, bz_a};
            else
                act = {score_b, st_b, so_b, high_b, ht_b, ho_b, pl_b, wn_b, ls_b, bz_b};
            vectors++;
            if (e.cyc != cyc) begin
                miscompares++;
                $display("FAIL %s: stale check at cycle %0d, required cycle %0d", e.name, cyc, e.cyc);
            end else if (act !== e.v) begin
                miscompares++;
                $display("FAIL %s (dut%0d cyc %0d): got score=%0d bcd=%h%h hi=%0d bcd=%h%h flags=%b busy=%b, want score=%0d bcd=%h%h hi=%0d bcd=%h%h flags=%b busy=%b",
                         e.name, e.which, cyc,
                         act[33:27], act[26:23], act[22:19], act[18:12], act[11:8], act[7:4], act[3:1], act[0],
                         e.v[33:27], e.v[26:23], e.v[22:19], e.v[18:12], e.v[11:8], e.v[7:4], e.v[3:1], e.v[0]);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic exp_out(input string nm, input int w, input int sc, input int hi,
                           input logic [2:0] fl, input logic bz);
        exp_t e;
        int   h;
`ifdef HISCORE_TRACK_EN
        h = hi;
`else
        h = 0;
`endif
        e.cyc   = cyc;
        e.which = w;
        e.name  = nm;
        e.v     = {7'(sc), 4'(sc / 10), 4'(sc % 10), 7'(h), 4'(h / 10), 4'(h % 10), fl, bz};
        sb.push_back(e);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached at cycle %0d, required completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        tick(2);
        exp_out("reset", 0, 0, 0, F_IDLE, 1'b0);
        exp_out("reset99", 1, 0, 0, F_IDLE, 1'b0);
        rst = 1'b0;
        clr = 1'b1; lines = 3'd4; top = 1'b1;
        tick(1);
        clr = 1'b0; top = 1'b0;
        exp_out("idle_ignores", 0, 0, 0, F_IDLE, 1'b0);

        start = 1'b1; tick(1); start = 1'b0;
        exp_out("start", 0, 0, 0, F_PLAY, 1'b0);
        clr = 1'b1; lines = 3'd4; tick(1); clr = 1'b0;
        exp_out("tetris_pend", 0, 0, 0, F_PLAY, 1'b1);
        for (int k = 1; k <= 8; k++) begin
            tick(1);
            exp_out("tetris_step", 0, k, k - 1, F_PLAY, (k < 8));
        end
        tick(1);
        exp_out("hi_follow", 0, 8, 8, F_PLAY, 1'b0);

        clr = 1'b1; lines = 3'd4; tick(1);
        exp_out("b2b_a", 0, 8, 8, F_PLAY, 1'b1);
        tick(1);
        exp_out("b2b_b", 0, 9, 8, F_PLAY, 1'b1);
        tick(1);
        exp_out("b2b_c", 0, 10, 9, F_PLAY, 1'b1);
        lines = 3'd3; tick(1);
        exp_out("b2b_d", 0, 11, 10, F_PLAY, 1'b1);
        lines = 3'd1; tick(1); clr = 1'b0;
        exp_out("b2b_e", 0, 12, 11, F_PLAY, 1'b1);
        tick(25);
        exp_out("drain_near", 0, 37, 36, F_PLAY, 1'b1);
        tick(1);
        exp_out("drain_done", 0, 38, 37, F_PLAY, 1'b0);
        clr = 1'b1; lines = 3'd7; tick(1);
        exp_out("zero_pts7", 0, 38, 38, F_PLAY, 1'b0);
        lines = 3'd0; tick(1); clr = 1'b0;
        exp_out("zero_pts0", 0, 38, 38, F_PLAY, 1'b0);

        clr = 1'b1; lines = 3'd2; tick(1); clr = 1'b0;
        exp_out("win_pend", 0, 38, 38, F_PLAY, 1'b1);
        tick(1);
        exp_out("win_39", 0, 39, 38, F_PLAY, 1'b1);
        tick(1);
        exp_out("win_40", 0, 40, 39, F_PLAY, 1'b1);
        tick(1);
        exp_out("win_enter", 0, 40, 40, F_WIN, 1'b0);
        clr = 1'b1; lines = 3'd4; top = 1'b1; tick(1); clr = 1'b0; top = 1'b0;
        exp_out("win_hold", 0, 40, 40, F_WIN, 1'b0);

        start = 1'b1; tick(1); start = 1'b0;
        exp_out("restart_win", 0, 0, 40, F_PLAY, 1'b0);
        clr = 1'b1; lines = 3'd4; tick(5); clr = 1'b0;
        exp_out("sat_fill", 0, 4, 40, F_PLAY, 1'b1);
        tick(30);
        exp_out("sat_near", 0, 34, 40, F_PLAY, 1'b1);
        tick(1);
        exp_out("sat_done", 0, 35, 40, F_PLAY, 1'b0);
        clr = 1'b1; lines = 3'd3; tick(1); clr = 1'b0;
        exp_out("five_pts", 0, 35, 40, F_PLAY, 1'b1);
        tick(4);
        exp_out("pre_top", 0, 39, 40, F_PLAY, 1'b1);
        top = 1'b1; tick(1); top = 1'b0;
        exp_out("top_vs_win", 0, 40, 40, F_LOSE, 1'b0);
        tick(1);
        exp_out("lose_hold", 0, 40, 40, F_LOSE, 1'b0);

        start = 1'b1; tick(1); start = 1'b0;
        exp_out("restart_lose", 0, 0, 40, F_PLAY, 1'b0);
        clr = 1'b1; lines = 3'd4; tick(1); clr = 1'b0;
        tick(3);
        exp_out("mid_inc", 0, 3, 40, F_PLAY, 1'b1);
        rst = 1'b1; tick(1); rst = 1'b0;
        exp_out("reset_mid", 0, 0, 0, F_IDLE, 1'b0);
        start = 1'b1; tick(1); start = 1'b0;
        exp_out("start_after_rst", 0, 0, 0, F_PLAY, 1'b0);

        clr = 1'b1; lines = 3'd4; tick(1);
        lines = 3'd2; tick(1);
        exp_out("mix_b", 0, 1, 0, F_PLAY, 1'b1);
        lines = 3'd1; tick(1); clr = 1'b0;
        exp_out("mix_c", 0, 2, 1, F_PLAY, 1'b1);
        tick(10);
        exp_out("mix_drain", 0, 12, 11, F_PLAY, 1'b0);
        tick(1);
        exp_out("hi_12", 0, 12, 12, F_PLAY, 1'b0);
        top = 1'b1; tick(1); top = 1'b0;
        exp_out("lose12", 0, 12, 12, F_LOSE, 1'b0);
        start = 1'b1; top = 1'b1; clr = 1'b1; lines = 3'd4;
        tick(1);
        start = 1'b0; top = 1'b0; clr = 1'b0;
        exp_out("start_prio", 0, 0, 12, F_PLAY, 1'b0);
        tick(1);
        exp_out("start_prio_hold", 0, 0, 12, F_PLAY, 1'b0);

        s9 = 1'b1; tick(1); s9 = 1'b0;
        exp_out("p99_start", 1, 0, 0, F_PLAY, 1'b0);
        c9 = 1'b1; l9 = 3'd4;
        tick(96);
        exp_out("p99_95", 1, 95, 94, F_PLAY, 1'b1);
        tick(4);
        exp_out("p99_sat", 1, 99, 98, F_PLAY, 1'b1);
        tick(1);
        exp_out("p99_win", 1, 99, 99, F_WIN, 1'b0);
        tick(1); c9 = 1'b0;
        exp_out("p99_hold", 1, 99, 99, F_WIN, 1'b0);

        repeat (2) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/game_status_ctrl.md
GAME_STATUS_CTRL -- requirements
Module: game_status_ctrl

Interface
REQ-001 SHALL have parameter WIN_SCORE, default 7'd40, the score (1..99) at which the game is won.
REQ-002 SHALL have port Clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port Reset  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port Start  input  1  one-cycle pulse that begins a new game.
REQ-005 SHALL have port Clear_Valid  input  1  one-cycle pulse: a line-clear event occurred.
REQ-006 SHALL have port Lines_Cleared  input  3  count of rows cleared, sampled when Clear_Valid=1.
REQ-007 SHALL have port Top_Out  input  1  one-cycle pulse: the stack reached the top.
REQ-008 SHALL have port Score  output  7  current score, binary, 0..99.
REQ-009 SHALL have port Score_Tens, Score_Ones  output  4 each  BCD digits of Score.
REQ-010 SHALL have port Highest  output  7  best score since Reset, binary.
REQ-011 SHALL have port Highest_Tens, Highest_Ones  output  4 each  BCD digits of Highest.
REQ-012 SHALL have port Playing, Win, Lose  output  1 each  one-hot registered state flags.
REQ-013 SHALL have port Busy  output  1  high while pending points are non-zero.

Function
REQ-014 SHALL implement states IDLE, PLAY, WIN, LOSE; Playing/Win/Lose = (state==PLAY/WIN/LOSE).
REQ-015 SHALL go from any state to PLAY on Start, clearing Score, its digits and pending to 0 in the same edge; Highest is kept.
REQ-016 SHALL ignore Clear_Valid and Top_Out outside PLAY.
REQ-017 SHALL map Lines_Cleared 1/2/3/4 to 1/3/5/8 points; 0, 5, 6 and 7 map to 0 points.
REQ-018 SHALL add the points to a 5-bit pending counter on Clear_Valid in PLAY, saturating at 31.
REQ-019 SHALL, each PLAY cycle with pending>0 and Score<99, increment Score by 1 and decrement pending by 1.
REQ-020 SHALL, when Clear_Valid and a decrement fall on the same cycle, set pending to pending+points-1 (saturated).
REQ-021 SHALL, on each increment, update Score_Ones and Score_Tens as a BCD counter (9 -> 0 with carry); no divider.
REQ-022 SHALL saturate Score at 99; at 99, pending is cleared to 0.
REQ-023 SHALL enter WIN on the edge after Score equals WIN_SCORE in PLAY, and discard pending.
REQ-024 SHALL enter LOSE on the edge after Top_Out in PLAY, and discard pending.
REQ-025 SHALL give Top_Out priority over a simultaneous win condition.
REQ-026 SHALL hold Score and state in WIN/LOSE until Start or Reset.
REQ-027 SHALL load Highest and its digits from Score one cycle after Score>Highest.
REQ-028 SHALL give Start priority over Clear_Valid and Top_Out on the same cycle.

Reset
REQ-029 SHALL, on Reset, clear state to IDLE, Score, Highest, all digits and pending to 0, with all flags and Busy at 0.
REQ-030 SHALL give Reset priority over every other input, including in the middle of an increment sequence.

Configuration
REQ-031 SHALL, with HISCORE_TRACK_EN defined, implement REQ-027.
REQ-032 SHALL, without HISCORE_TRACK_EN, tie Highest, Highest_Tens and Highest_Ones to 0 and omit the Highest registers.

Verification
REQ-033 SHALL cover Reset, Start, then Clear_Valid with Lines_Cleared=4 -> Busy for 8 cycles; Score=8, digits 0/8, then Highest=8 one cycle later.
REQ-034 SHALL cover Score=38, then Clear_Valid with Lines_Cleared=2 -> Score steps 39, 40; WIN on the next edge; the 1 remaining pending point is dropped and Score stays 40.
REQ-035 SHALL cover Top_Out and the edge that makes Score=WIN_SCORE on the same cycle -> LOSE.
REQ-036 SHALL cover repeated 4-line clears with WIN_SCORE=99 from Score=95 -> Score saturates at 99, pending=0, then WIN.
REQ-037 SHALL cover Reset asserted mid-increment with pending=5 -> next cycle IDLE, all outputs 0; Start then gives PLAY with Score=0.
REQ-038 SHALL cover Start in LOSE with Highest=12 -> PLAY, Score=0, Highest stays 12 (0 when HISCORE_TRACK_EN is undefined).
